// File: rtl/uart_tx_sched.sv
// uart_tx_sched: schedules 16-bit TX FIFO words onto a byte-wide UART
// transmitter and generates the baud tick from the programmed divisor.
// Optional feature: define UART_TX_SCHED_STATS_EN to add the word_cnt output,
// a wrapping count of words fully handed to the transmitter.
module uart_tx_sched #(
   parameter int BAUD_W = 16,
   parameter int WORD_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [1:0]        control,
   input  logic [BAUD_W-1:0] baud,
   input  logic [WORD_W-1:0] tx_fifo_dout,
   input  logic              tx_fifo_empty,
   output logic              tx_fifo_rd,
   output logic [7:0]        tx_byte,
   output logic              tx_byte_valid,
   input  logic              tx_byte_ready,
   output logic              baud_tick,
   output logic [3:0]        state
`ifdef UART_TX_SCHED_STATS_EN
   ,
   output logic [15:0]       word_cnt
`endif
);

   typedef enum logic [2:0] {
      IDLE,
      POP,
      LATCH,
      SEND0,
      SEND1
   } fsm_t;

   fsm_t              fsm;
   logic [BAUD_W-1:0] cnt;
   logic [WORD_W-1:0] word_q;
   logic              hi_first;

   logic              tx_en;
   logic              baud_zero;
   logic [BAUD_W-1:0] baud_m1;
   logic              hs;

   assign tx_en     = control[0];
   assign baud_zero = (baud == '0);
   assign baud_m1   = baud - BAUD_W'(1);
   assign hs        = tx_byte_valid & tx_byte_ready;

   // The tick is decoded from the live divisor, so lowering baud below the
   // current count suppresses the tick in that same cycle.
   assign baud_tick = !baud_zero && (cnt == baud_m1);

   // Tick counter: 0..baud-1, held at 0 while halted, cleared if overshot.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses <= so every register samples pre-edge values.
      if (!rst_n) begin
         cnt <= '0;
      end else if (baud_zero || (cnt >= baud_m1)) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + BAUD_W'(1);
      end
   end

   // Word scheduler: pop, wait for read latency, latch, then send two bytes.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fsm           <= IDLE;
         tx_fifo_rd    <= 1'b0;
         tx_byte       <= '0;
         tx_byte_valid <= 1'b0;
         // NOTE: the word latch is a plain register, so it is reset with the rest.
         word_q        <= '0;
         hi_first      <= 1'b0;
      end else begin
         tx_fifo_rd <= 1'b0;
         case (fsm)
            IDLE: begin
               if (tx_en && !tx_fifo_empty && !baud_zero) begin
                  tx_fifo_rd <= 1'b1;
                  fsm        <= POP;
               end
            end
            POP: begin
               fsm <= LATCH;
            end
            LATCH: begin
               // Byte order is frozen here for the whole word.
               word_q        <= tx_fifo_dout;
               hi_first      <= control[1];
               tx_byte       <= control[1] ? tx_fifo_dout[15:8] : tx_fifo_dout[7:0];
               tx_byte_valid <= 1'b1;
               fsm           <= SEND0;
            end
            SEND0: begin
               if (hs) begin
                  tx_byte <= hi_first ? word_q[7:0] : word_q[15:8];
                  fsm     <= SEND1;
               end
            end
            SEND1: begin
               if (hs) begin
                  tx_byte       <= '0;
                  tx_byte_valid <= 1'b0;
                  fsm           <= IDLE;
               end
            end
            default: begin
               fsm <= IDLE;
            end
         endcase
      end
   end

   // Status word; bit3 is a sticky baud error that only tx_en=0 clears.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= {3'b000, tx_fifo_empty};
      end else begin
         state[0] <= tx_fifo_empty;
         state[1] <= (fsm != IDLE);
         state[2] <= tx_en;
         state[3] <= tx_en & (state[3] | (baud_zero & ~tx_fifo_empty));
      end
   end

`ifdef UART_TX_SCHED_STATS_EN
   // Completed-word counter; state[2] holds last cycle's tx_en for edge detect.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         word_cnt <= '0;
      end else if (tx_en && !state[2]) begin
         word_cnt <= '0;
      end else if ((fsm == SEND1) && hs) begin
         word_cnt <= word_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed testbench for uart_tx_sched. Models a FIFO with one-cycle read
// latency and a byte sink that logs every accepted byte.
module tb_uart_tx_sched;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  control = 2'b00;
   logic [15:0] baud = 16'd4;
   logic [15:0] tx_fifo_dout = 16'h0000;
   logic        tx_fifo_empty;
   logic        tx_fifo_rd;
   logic [7:0]  tx_byte;
   logic        tx_byte_valid;
   logic        tx_byte_ready = 1'b1;
   logic        baud_tick;
   logic [3:0]  state;
`ifdef UART_TX_SCHED_STATS_EN
   logic [15:0] word_cnt;
`endif

   int n_checks = 0;
   int n_fails  = 0;

   // FIFO model
   logic [15:0] fmem [0:15];
   int          wr_ptr = 0;
   int          rd_ptr = 0;
   int          n_pops = 0;
   logic        rd_on_empty = 1'b0;

   // Accepted-byte log
   logic [7:0]  blog [0:63];
   int          nb = 0;

   assign tx_fifo_empty = (wr_ptr == rd_ptr);

   always #5 clk = ~clk;

   uart_tx_sched dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .control       (control),
      .baud          (baud),
      .tx_fifo_dout  (tx_fifo_dout),
      .tx_fifo_empty (tx_fifo_empty),
      .tx_fifo_rd    (tx_fifo_rd),
      .tx_byte       (tx_byte),
      .tx_byte_valid (tx_byte_valid),
      .tx_byte_ready (tx_byte_ready),
      .baud_tick     (baud_tick),
      .state         (state)
`ifdef UART_TX_SCHED_STATS_EN
      ,
      .word_cnt      (word_cnt)
`endif
   );

   // FIFO read port and transmitter sink
   always @(posedge clk) begin
      if (tx_fifo_rd) begin
         if (wr_ptr == rd_ptr) begin
            rd_on_empty <= 1'b1;
         end else begin
            tx_fifo_dout <= fmem[rd_ptr % 16];
            rd_ptr       <= rd_ptr + 1;
            n_pops       <= n_pops + 1;
         end
      end
      if (rst_n && tx_byte_valid && tx_byte_ready) begin
         blog[nb % 64] <= tx_byte;
         nb            <= nb + 1;
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [15:0] w);
      fmem[wr_ptr % 16] = w;
      wr_ptr = wr_ptr + 1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      control = 2'b00;
      baud = 16'd4;
      tx_byte_ready = 1'b1;
      cyc();
      cyc();
      n_checks++; if (tx_fifo_rd !== 1'b0) begin n_fails++; $display("FAIL reset_rd: got %b expected 0", tx_fifo_rd); end
      n_checks++; if (tx_byte !== 8'h00) begin n_fails++; $display("FAIL reset_byte: got %h expected 00", tx_byte); end
      n_checks++; if (tx_byte_valid !== 1'b0) begin n_fails++; $display("FAIL reset_valid: got %b expected 0", tx_byte_valid); end
      n_checks++; if (baud_tick !== 1'b0) begin n_fails++; $display("FAIL reset_tick: got %b expected 0", baud_tick); end
      n_checks++; if (state !== 4'b0001) begin n_fails++; $display("FAIL reset_state: got %b expected 0001", state); end
`ifdef UART_TX_SCHED_STATS_EN
      n_checks++; if (word_cnt !== 16'd0) begin n_fails++; $display("FAIL reset_word_cnt: got %0d expected 0", word_cnt); end
`endif
      rst_n = 1'b1;
      cyc();
   endtask

   task automatic test_baud_tick();
      logic found;
      logic exp;
      control = 2'b00;
      baud = 16'd4;
      found = 1'b0;
      for (int i = 0; i < 8; i++) begin
         cyc();
         if (baud_tick) begin
            found = 1'b1;
            break;
         end
      end
      n_checks++; if (found !== 1'b1) begin n_fails++; $display("FAIL tick_found: got %b expected 1", found); end
      // From a tick, baud=4 gives the next ticks 4 and 8 cycles later
      for (int i = 1; i <= 8; i++) begin
         cyc();
         exp = ((i % 4) == 0);
         n_checks++; if (baud_tick !== exp) begin n_fails++; $display("FAIL tick_div4[%0d]: got %b expected %b", i, baud_tick, exp); end
      end
      // Counter is at 3 now; dropping the divisor to 2 kills this tick
      baud = 16'd2;
      #1;
      n_checks++; if (baud_tick !== 1'b0) begin n_fails++; $display("FAIL tick_lowered_same_cycle: got %b expected 0", baud_tick); end
      for (int i = 1; i <= 4; i++) begin
         cyc();
         exp = ((i % 2) == 0);
         n_checks++; if (baud_tick !== exp) begin n_fails++; $display("FAIL tick_div2[%0d]: got %b expected %b", i, baud_tick, exp); end
      end
      baud = 16'd1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         n_checks++; if (baud_tick !== 1'b1) begin n_fails++; $display("FAIL tick_div1[%0d]: got %b expected 1", i, baud_tick); end
      end
      baud = 16'd0;
      for (int i = 0; i < 6; i++) begin
         cyc();
         n_checks++; if (baud_tick !== 1'b0) begin n_fails++; $display("FAIL tick_halted[%0d]: got %b expected 0", i, baud_tick); end
      end
      baud = 16'd4;
      cyc();
   endtask

   task automatic run_word(input logic [1:0] ctl, input logic [15:0] w,
                           input logic [7:0] b0, input logic [7:0] b1, input string tag);
      int s;
      int p;
      int rd_cycles;
      int busy_cycles;
      s = nb;
      p = n_pops;
      rd_cycles = 0;
      busy_cycles = 0;
      push(w);
      control = ctl;
      for (int i = 0; i < 12; i++) begin
         cyc();
         if (tx_fifo_rd) rd_cycles++;
         if (state[1]) busy_cycles++;
      end
      n_checks++; if (rd_cycles !== 1) begin n_fails++; $display("FAIL %s rd_cycles: got %0d expected 1", tag, rd_cycles); end
      // Busy covers POP, LATCH, SEND0 and SEND1, seen one cycle late
      n_checks++; if (busy_cycles !== 4) begin n_fails++; $display("FAIL %s busy_cycles: got %0d expected 4", tag, busy_cycles); end
      n_checks++; if (nb - s !== 2) begin n_fails++; $display("FAIL %s byte_count: got %0d expected 2", tag, nb - s); end
      n_checks++; if (blog[s % 64] !== b0) begin n_fails++; $display("FAIL %s byte0: got %h expected %h", tag, blog[s % 64], b0); end
      n_checks++; if (blog[(s + 1) % 64] !== b1) begin n_fails++; $display("FAIL %s byte1: got %h expected %h", tag, blog[(s + 1) % 64], b1); end
      n_checks++; if (n_pops - p !== 1) begin n_fails++; $display("FAIL %s pops: got %0d expected 1", tag, n_pops - p); end
      n_checks++; if (state !== 4'b0101) begin n_fails++; $display("FAIL %s end_state: got %b expected 0101", tag, state); end
      control = 2'b00;
      cyc();
   endtask

   task automatic test_byte_order();
      run_word(2'b01, 16'hA55A, 8'h5A, 8'hA5, "low_first");
      run_word(2'b11, 16'hA55A, 8'hA5, 8'h5A, "high_first");
   endtask

   task automatic test_stall_and_disable();
      int   s;
      int   p;
      logic got;
      s = nb;
      p = n_pops;
      tx_byte_ready = 1'b0;
      push(16'h1234);
      push(16'h5678);
      control = 2'b11;
      got = 1'b0;
      for (int i = 0; i < 10; i++) begin
         cyc();
         if (tx_byte_valid) begin
            got = 1'b1;
            break;
         end
      end
      n_checks++; if (got !== 1'b1) begin n_fails++; $display("FAIL stall_valid_seen: got %b expected 1", got); end
      n_checks++; if (tx_byte !== 8'h12) begin n_fails++; $display("FAIL stall_first_byte: got %h expected 12", tx_byte); end
      // Drop tx_en and flip the order bit while stalled in SEND0
      control = 2'b00;
      for (int i = 0; i < 10; i++) begin
         cyc();
         n_checks++; if (tx_byte_valid !== 1'b1) begin n_fails++; $display("FAIL stall_valid[%0d]: got %b expected 1", i, tx_byte_valid); end
         n_checks++; if (tx_byte !== 8'h12) begin n_fails++; $display("FAIL stall_byte[%0d]: got %h expected 12", i, tx_byte); end
      end
      tx_byte_ready = 1'b1;
      for (int i = 0; i < 10; i++) cyc();
      n_checks++; if (nb - s !== 2) begin n_fails++; $display("FAIL disable_byte_count: got %0d expected 2", nb - s); end
      n_checks++; if (blog[s % 64] !== 8'h12) begin n_fails++; $display("FAIL disable_byte0: got %h expected 12", blog[s % 64]); end
      n_checks++; if (blog[(s + 1) % 64] !== 8'h34) begin n_fails++; $display("FAIL disable_byte1: got %h expected 34", blog[(s + 1) % 64]); end
      n_checks++; if (n_pops - p !== 1) begin n_fails++; $display("FAIL disable_pops: got %0d expected 1", n_pops - p); end
      n_checks++; if (wr_ptr - rd_ptr !== 1) begin n_fails++; $display("FAIL disable_fifo_left: got %0d expected 1", wr_ptr - rd_ptr); end
      n_checks++; if (state !== 4'b0000) begin n_fails++; $display("FAIL disable_state: got %b expected 0000", state); end
      // Re-enable low-first to drain the remaining word
      control = 2'b01;
      for (int i = 0; i < 12; i++) cyc();
      n_checks++; if (nb - s !== 4) begin n_fails++; $display("FAIL drain_byte_count: got %0d expected 4", nb - s); end
      n_checks++; if (blog[(s + 2) % 64] !== 8'h78) begin n_fails++; $display("FAIL drain_byte0: got %h expected 78", blog[(s + 2) % 64]); end
      n_checks++; if (blog[(s + 3) % 64] !== 8'h56) begin n_fails++; $display("FAIL drain_byte1: got %h expected 56", blog[(s + 3) % 64]); end
      n_checks++; if (tx_fifo_empty !== 1'b1) begin n_fails++; $display("FAIL drain_empty: got %b expected 1", tx_fifo_empty); end
      control = 2'b00;
      cyc();
   endtask

   task automatic test_baud_error();
      int s;
      int rd_cycles;
      s = nb;
      control = 2'b00;
      baud = 16'd0;
      push(16'hC33C);
      cyc();
      cyc();
      n_checks++; if (state[3] !== 1'b0) begin n_fails++; $display("FAIL err_without_en: got %b expected 0", state[3]); end
      control = 2'b01;
      rd_cycles = 0;
      for (int i = 0; i < 6; i++) begin
         cyc();
         if (tx_fifo_rd) rd_cycles++;
      end
      n_checks++; if (rd_cycles !== 0) begin n_fails++; $display("FAIL err_no_pop: got %0d expected 0", rd_cycles); end
      n_checks++; if (state !== 4'b1100) begin n_fails++; $display("FAIL err_state: got %b expected 1100", state); end
      baud = 16'd8;
      rd_cycles = 0;
      for (int i = 0; i < 10; i++) begin
         cyc();
         if (tx_fifo_rd) rd_cycles++;
      end
      n_checks++; if (rd_cycles !== 1) begin n_fails++; $display("FAIL err_pop_resumes: got %0d expected 1", rd_cycles); end
      n_checks++; if (nb - s !== 2) begin n_fails++; $display("FAIL err_byte_count: got %0d expected 2", nb - s); end
      n_checks++; if (blog[s % 64] !== 8'h3C) begin n_fails++; $display("FAIL err_byte0: got %h expected 3C", blog[s % 64]); end
      n_checks++; if (blog[(s + 1) % 64] !== 8'hC3) begin n_fails++; $display("FAIL err_byte1: got %h expected C3", blog[(s + 1) % 64]); end
      n_checks++; if (state[3] !== 1'b1) begin n_fails++; $display("FAIL err_sticky: got %b expected 1", state[3]); end
      control = 2'b00;
      cyc();
      n_checks++; if (state[3] !== 1'b0) begin n_fails++; $display("FAIL err_cleared: got %b expected 0", state[3]); end
      baud = 16'd4;
      cyc();
   endtask

   task automatic test_reset_mid_word();
      int   s;
      int   p;
      logic got;
      s = nb;
      p = n_pops;
      tx_byte_ready = 1'b1;
      push(16'hBEEF);
      control = 2'b01;
      got = 1'b0;
      for (int i = 0; i < 10; i++) begin
         cyc();
         if (nb == s + 1) begin
            got = 1'b1;
            break;
         end
      end
      n_checks++; if (got !== 1'b1) begin n_fails++; $display("FAIL midreset_reach_send1: got %b expected 1", got); end
      n_checks++; if (tx_byte !== 8'hBE) begin n_fails++; $display("FAIL midreset_send1_byte: got %h expected BE", tx_byte); end
      rst_n = 1'b0;
      cyc();
      n_checks++; if (tx_byte_valid !== 1'b0) begin n_fails++; $display("FAIL midreset_valid: got %b expected 0", tx_byte_valid); end
      n_checks++; if (tx_byte !== 8'h00) begin n_fails++; $display("FAIL midreset_byte: got %h expected 00", tx_byte); end
      n_checks++; if (state !== 4'b0001) begin n_fails++; $display("FAIL midreset_state: got %b expected 0001", state); end
`ifdef UART_TX_SCHED_STATS_EN
      n_checks++; if (word_cnt !== 16'd0) begin n_fails++; $display("FAIL midreset_word_cnt: got %0d expected 0", word_cnt); end
`endif
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) cyc();
      n_checks++; if (state[1] !== 1'b0) begin n_fails++; $display("FAIL midreset_idle: got %b expected 0", state[1]); end
      n_checks++; if (nb !== s + 1) begin n_fails++; $display("FAIL midreset_byte_dropped: got %0d expected %0d", nb, s + 1); end
      n_checks++; if (n_pops !== p + 1) begin n_fails++; $display("FAIL midreset_no_repop: got %0d expected %0d", n_pops, p + 1); end
   endtask

   task automatic test_back_to_back();
      int         s;
      logic [7:0] exp [0:5];
      exp[0] = 8'h02; exp[1] = 8'h01; exp[2] = 8'h04;
      exp[3] = 8'h03; exp[4] = 8'h06; exp[5] = 8'h05;
      s = nb;
      push(16'h0102);
      push(16'h0304);
      push(16'h0506);
      control = 2'b01;
      for (int i = 0; i < 25; i++) cyc();
      n_checks++; if (nb - s !== 6) begin n_fails++; $display("FAIL b2b_byte_count: got %0d expected 6", nb - s); end
      for (int i = 0; i < 6; i++) begin
         n_checks++; if (blog[(s + i) % 64] !== exp[i]) begin n_fails++; $display("FAIL b2b_byte[%0d]: got %h expected %h", i, blog[(s + i) % 64], exp[i]); end
      end
`ifdef UART_TX_SCHED_STATS_EN
      n_checks++; if (word_cnt !== 16'd3) begin n_fails++; $display("FAIL b2b_word_cnt: got %0d expected 3", word_cnt); end
`endif
      control = 2'b00;
      cyc();
   endtask

   initial begin
      test_reset();
      test_baud_tick();
      test_byte_order();
      test_stall_and_disable();
      test_baud_error();
      test_reset_mid_word();
      test_back_to_back();
      n_checks++; if (rd_on_empty !== 1'b0) begin n_fails++; $display("FAIL rd_on_empty: got %b expected 0", rd_on_empty); end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
